// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at issue, held in shadow registers, committed after the latency.
module md_unit #(
    parameter int W        = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   MADOP,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cancel,
    output logic [W-1:0] HI,
    output logic [W-1:0] LO,
    output logic         busy,
    output logic         done
);

    localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    hi_s, lo_s;
    logic            commit;

    logic is_mult, is_multu, is_mthi, is_mtlo, is_div, is_divu;
    logic accept, md_go;

    always_comb begin
        is_mult  = 1'b0;
        is_multu = 1'b0;
        is_mthi  = 1'b0;
        is_mtlo  = 1'b0;
        is_div   = 1'b0;
        is_divu  = 1'b0;
        case (MADOP)
            4'd1:    is_mult  = 1'b1;
            4'd2:    is_multu = 1'b1;
            4'd3:    is_mthi  = 1'b1;
            4'd4:    is_mtlo  = 1'b1;
            4'd5:    is_div   = 1'b1;
            4'd6:    is_divu  = 1'b1;
            default: ;
        endcase
    end

    assign busy   = (state == RUN);
    assign accept = start & ~cancel & ~busy;
    assign md_go  = accept & (is_mult | is_multu | is_div | is_divu);

    logic [2*W-1:0] ax, bx, prod;

    assign ax   = is_mult ? {{W{A[W-1]}}, A} : {{W{1'b0}}, A};
    assign bx   = is_mult ? {{W{B[W-1]}}, B} : {{W{1'b0}}, B};
    assign prod = ax * bx;

    logic [W-1:0] abs_a, abs_b, bsafe, uq, ur, q, r;
    logic [W-1:0] min_neg, res_hi, res_lo;
    logic         ovf;

    assign min_neg = {1'b1, {(W-1){1'b0}}};
    assign abs_a   = (is_div & A[W-1]) ? -A : A;
    assign abs_b   = (is_div & B[W-1]) ? -B : B;
    // substitute divisor keeps the divider defined; B==0 is overridden below
    assign bsafe   = (abs_b == '0) ? W'(1) : abs_b;
    assign uq      = abs_a / bsafe;
    assign ur      = abs_a % bsafe;
    assign q       = (is_div & (A[W-1] ^ B[W-1])) ? -uq : uq;
    assign r       = (is_div & A[W-1]) ? -ur : ur;
    assign ovf     = is_div & (A == min_neg) & (B == '1);

    always_comb begin
        res_hi = r;
        res_lo = q;
        if (is_mult | is_multu) begin
            res_hi = prod[2*W-1:W];
            res_lo = prod[W-1:0];
        end else if (B == '0) begin
            res_hi = A;
            res_lo = '1;
        end else if (ovf) begin
            res_hi = '0;
            res_lo = min_neg;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (md_go) begin
                    state_n = RUN;
                    cnt_n   = (is_mult | is_multu) ? CW'(MULT_LAT)
                                                   : CW'(DIV_LAT);
                end
            end
            RUN: begin
                if (cancel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CW'(1)) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi_s  <= '0;
            lo_s  <= '0;
            HI    <= '0;
            LO    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            done  <= commit;
            if (md_go) begin
                hi_s <= res_hi;
                lo_s <= res_lo;
            end
            if (accept & is_mthi) HI <= A;
            if (accept & is_mtlo) LO <= A;
            if (commit) begin
                HI <= hi_s;
                LO <= lo_s;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expectations queued at issue,
// compared by a monitor whenever done pulses.
module tb_md_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   MADOP;
    logic [W-1:0] A, B;
    logic         cancel;
    logic [W-1:0] HI, LO;
    logic         busy, done;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    md_unit #(.W(W), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MADOP(MADOP),
        .A(A), .B(B), .cancel(cancel),
        .HI(HI), .LO(LO), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("hilo_commit", {HI, LO}, e);
            end
        end
    end

    task automatic mt(input logic [3:0] op, input logic [W-1:0] a,
                      input logic can);
        @(negedge clk);
        start = 1'b1; MADOP = op; A = a; cancel = can;
        @(negedge clk);
        start = 1'b0; MADOP = 4'd0; cancel = 1'b0;
    endtask

    task automatic run_md(input string name, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int lat);
        int n;
        exp_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b1; MADOP = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; MADOP = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_len"}, 64'(n), 64'(lat));
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; MADOP = 4'd0;
        A = '0; B = '0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        mt(4'd3, 32'h1234, 1'b0);
        chk("mthi_hi", 64'(HI), 64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);

        run_md("mult", 4'd1, 32'hFFFFFFFE, 32'd3,
               32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        run_md("multu", 4'd2, 32'hFFFFFFFE, 32'd3,
               32'h00000002, 32'hFFFFFFFA, 5);
        run_md("div", 4'd5, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_md("divu", 4'd6, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        run_md("divu_z", 4'd6, 32'd5, 32'd0,
               32'd5, 32'hFFFFFFFF, 10);
        run_md("div_z", 4'd5, 32'hFFFFFFF9, 32'd0,
               32'hFFFFFFF9, 32'hFFFFFFFF, 10);
        run_md("div_ovf", 4'd5, 32'h80000000, 32'hFFFFFFFF,
               32'd0, 32'h80000000, 10);

        mt(4'd3, 32'h11, 1'b0);
        mt(4'd4, 32'h22, 1'b0);
        chk("mt_hi", 64'(HI), 64'h11);
        chk("mt_lo", 64'(LO), 64'h22);

        // MULT aborted on its third busy cycle
        @(negedge clk);
        start = 1'b1; MADOP = 4'd1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0; MADOP = 4'd0;
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_hilo", {HI, LO}, {32'h11, 32'h22});
        chk("cancel_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("cancel_done2", 64'(done), 64'd0);

        mt(4'd4, 32'd9, 1'b1);
        chk("sc_mtlo_lo", 64'(LO), 64'h22);
        chk("sc_mtlo_busy", 64'(busy), 64'd0);

        // MULT issued while a DIV runs must be ignored
        exp_q.push_back({32'd2, 32'd14});
        @(negedge clk);
        start = 1'b1; MADOP = 4'd5; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; MADOP = 4'd0;
        n = 1;
        @(negedge clk);
        n++;
        start = 1'b1; MADOP = 4'd1; A = 32'd5; B = 32'd5;
        @(negedge clk);
        start = 1'b0; MADOP = 4'd0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("collide_busy_len", 64'(n), 64'd10);
        @(negedge clk);
        chk("collide_idle", 64'(busy), 64'd0);

        // async reset between edges while RUN
        @(negedge clk);
        start = 1'b1; MADOP = 4'd1; A = 32'd6; B = 32'd7;
        @(negedge clk);
        start = 1'b0; MADOP = 4'd0;
        @(negedge clk);
        chk("pre_areset_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("areset_hilo", {HI, LO}, 64'd0);
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("areset_no_commit", {HI, LO}, 64'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
